// File: rtl/joyser_pkg.sv
// Shared constants, state encoding and frame bit map for the joystick serializer.
// JOYSER_AUTOFIRE_EN enables the autofire phase logic in the top.
package joyser_pkg;

    localparam int JOYSER_FRAME_BITS = 24;
    localparam int JOYSER_AF_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    typedef struct packed {
        logic       pad;
        logic [3:0] idx;
    } map_t;

    // Serial index -> {pad (0 = pad 1, 1 = pad 2), bit of that pad}
    localparam map_t FRAME_MAP [JOYSER_FRAME_BITS] = '{
        '{1'b0, 4'd8}, '{1'b0, 4'd6}, '{1'b0, 4'd5}, '{1'b0, 4'd4},
        '{1'b0, 4'd3}, '{1'b0, 4'd2}, '{1'b0, 4'd1}, '{1'b0, 4'd0},
        '{1'b1, 4'd8}, '{1'b1, 4'd6}, '{1'b1, 4'd5}, '{1'b1, 4'd4},
        '{1'b1, 4'd3}, '{1'b1, 4'd2}, '{1'b1, 4'd1}, '{1'b1, 4'd0},
        '{1'b1, 4'd10}, '{1'b1, 4'd11}, '{1'b1, 4'd9}, '{1'b1, 4'd7},
        '{1'b0, 4'd10}, '{1'b0, 4'd11}, '{1'b0, 4'd9}, '{1'b0, 4'd7}
    };

    function automatic logic [JOYSER_FRAME_BITS-1:0] map_frame(
        input logic [11:0] j1,
        input logic [11:0] j2
    );
        logic [JOYSER_FRAME_BITS-1:0] f;
        for (int i = 0; i < JOYSER_FRAME_BITS; i++) begin
            f[i] = FRAME_MAP[i].pad ? j2[FRAME_MAP[i].idx]
                                    : j1[FRAME_MAP[i].idx];
        end
        return f;
    endfunction

endpackage

// File: rtl/joy_serializer_if.sv
// Joystick link bundle: pad words, link clock/load in, serial data and frame pulse out.
// autofire_en exists only when JOYSER_AUTOFIRE_EN is defined.
interface joy_serializer_if;

    logic [11:0] joy1_n;
    logic [11:0] joy2_n;
    logic        joy_clk_in;
    logic        joy_load_in;
    logic        joy_data_out;
    logic        frame_done;
`ifdef JOYSER_AUTOFIRE_EN
    logic [1:0]  autofire_en;
`endif

    modport master (
`ifdef JOYSER_AUTOFIRE_EN
        output autofire_en,
`endif
        output joy1_n, joy2_n, joy_clk_in, joy_load_in,
        input  joy_data_out, frame_done
    );

    modport slave (
`ifdef JOYSER_AUTOFIRE_EN
        input  autofire_en,
`endif
        input  joy1_n, joy2_n, joy_clk_in, joy_load_in,
        output joy_data_out, frame_done
    );

endinterface

// File: rtl/joyser_sync.sv
// Two-flop synchronizer plus history flop with rise/fall detect.
// Resets to all ones so an idle-high line produces no edge.
module joyser_sync (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic hist;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= d;
            sync <= meta;
            hist <= sync;
        end
    end

    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/joy_serializer.sv
// Board-side parallel-in/serial-out joystick link driver (two 12-bit pads).
// Define JOYSER_AUTOFIRE_EN to add the per-pad autofire phase on the fire bit.
module joy_serializer
    import joyser_pkg::*;
#(
    parameter int FRAME_BITS = JOYSER_FRAME_BITS
`ifdef JOYSER_AUTOFIRE_EN
    , parameter int AF_DIV = JOYSER_AF_DIV
`endif
) (
    input  logic            clk_sys,
    input  logic            reset,
    joy_serializer_if.slave link
);

    localparam int FW = JOYSER_FRAME_BITS;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_END  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

    logic clk_sync, clk_rise, clk_fall;
    logic ld_sync, ld_rise, ld_fall;
    logic unused_edges;

    joyser_sync u_clk_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (link.joy_clk_in),
        .sync    (clk_sync),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    joyser_sync u_ld_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (link.joy_load_in),
        .sync    (ld_sync),
        .rise    (ld_rise),
        .fall    (ld_fall)
    );

    assign unused_edges = clk_sync ^ clk_fall ^ ld_fall;

    state_t          state_q, state_d;
    logic [FW-1:0]   sr_q, sr_d, frame_now;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            data_q, data_d;
    logic            done_q, done_d;
    logic [11:0]     j1m, j2m;
    logic            load_lo, shift_ev, fin;

    assign load_lo  = ~ld_sync;
    assign shift_ev = clk_rise & ~load_lo & (state_q != IDLE);
    assign fin      = shift_ev & (cnt_q == CNT_LAST);

`ifdef JOYSER_AUTOFIRE_EN
    localparam int AW = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    logic [AW-1:0] af_cnt;
    logic          af_phase;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (done_q) begin
            if (af_cnt == AW'(AF_DIV - 1)) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + AW'(1);
            end
        end
    end

    // A pressed fire bit (0) reads released in phase-1 frames
    always_comb begin
        j1m    = link.joy1_n;
        j2m    = link.joy2_n;
        j1m[4] = link.joy1_n[4] | (af_phase & link.autofire_en[0]);
        j2m[4] = link.joy2_n[4] | (af_phase & link.autofire_en[1]);
    end
`else
    assign j1m = link.joy1_n;
    assign j2m = link.joy2_n;
`endif

    assign frame_now = map_frame(j1m, j2m);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '1;
            cnt_q   <= CNT_END;
            data_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            load_lo:         state_d = LOAD;
            fin:             state_d = IDLE;
            ld_rise & ~fin:  state_d = SHIFT;
            default:         state_d = state_q;
        endcase
    end

    // Load beats a coincident shift; the last shift forces the idle level
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        done_d = 1'b0;
        unique case (1'b1)
            load_lo: begin
                sr_d   = frame_now;
                cnt_d  = '0;
                data_d = frame_now[0];
            end
            shift_ev: begin
                sr_d   = {1'b1, sr_q[FW-1:1]};
                cnt_d  = cnt_q + CW'(1);
                data_d = fin | sr_q[1];
                done_d = fin;
            end
            default: ;
        endcase
    end

    assign link.joy_data_out = data_q;
    assign link.frame_done   = done_q;

endmodule
